bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 16: bit width of the binary input.
REQ-002 SHALL have parameter DIGITS, default 5: number of BCD output digits.
- Legal only when 10^DIGITS > 2^WIDTH-1.
- Illegal combinations are unsupported and need no checking.

Ports:
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: conversion request, sampled only in IDLE.
REQ-006 SHALL have port bin, input, WIDTH: binary operand, captured on the edge that accepts start.
REQ-007 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse marking a completed conversion.
REQ-009 SHALL have port bcd, output, 4*DIGITS: result digits.
- Digit i occupies bits [4i+3:4i]; digit 0 is the least significant.
- Each nibble is directly consumable by the team's BCD-to-7-segment decoder.

Function
REQ-010 SHALL implement a two-state machine, IDLE and SHIFT, performing serial double-dabble (shift-add-3), one input bit per clock.
REQ-011 In IDLE with start=1 at a rising edge, the block SHALL:
- capture bin into a shift register;
- clear the working BCD register;
- clear the iteration counter;
- enter SHIFT.
REQ-012 In IDLE with start=0, the block SHALL hold all state.
REQ-013 Each SHIFT-state edge SHALL perform one iteration:
- add 3 to every working digit that is >= 5;
- then left-shift the concatenation {working BCD, binary shift register} by one bit, with the binary MSB entering digit 0 bit 0;
- increment the counter.
REQ-014 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during a conversion.
REQ-015 On the edge completing iteration WIDTH, the block SHALL:
- load the final working digits into the bcd output register;
- assert done;
- return to IDLE.
REQ-016 busy SHALL equal 1 exactly while the state is SHIFT: WIDTH consecutive cycles per conversion.
REQ-017 Latency SHALL be fixed: done is high in the cycle following the WIDTH-th edge after the accepting edge, i.e. the cycle after edge WIDTH (16 by default).
REQ-018 done SHALL be high for exactly one cycle per conversion and SHALL be low at all other times.
REQ-019 bcd SHALL change only on a completion edge and SHALL hold its value until the next completion.
REQ-020 start asserted while busy=1 SHALL be ignored; it is not queued and bin is not sampled.
REQ-021 start asserted in the done cycle (state IDLE) SHALL be accepted, giving back-to-back conversions with a WIDTH+1 cycle period.
REQ-022 Every output digit SHALL be in the range 0..9; no intermediate (pre-final) working value SHALL ever appear on bcd.
REQ-023 The block SHALL be fully deterministic; the result depends only on the bin value captured at acceptance, regardless of later changes to bin.

Reset
REQ-024 While rst_n=0, regardless of clk, the block SHALL force:
- state = IDLE;
- busy = 0;
- done = 0;
- bcd = all zeros;
- counter and shift registers = 0.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no done pulse, and bcd SHALL read zero.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 The bench SHALL cover these directed scenarios (default parameters):
- bin=0, start pulse -> busy high 16 cycles, done one cycle, bcd=0x00000.
- bin=65535 -> bcd=0x65535 on done.
- bin=9999 -> bcd=0x09999.
- bin=1234 -> bcd=0x01234.
- bin=42 then start=1 held continuously, bin changed to 7 while busy -> first result 0x00042; second conversion accepted in the done cycle; result 0x00007 exactly 17 cycles after the first done.
- bin=500, rst_n pulsed low at busy cycle 8 -> busy=0, done never asserts, bcd=0x00000; a subsequent bin=500 conversion -> bcd=0x00500.
REQ-028 The bench SHALL run a randomized sweep of at least 1000 values against a reference divide/modulo model.
- It SHALL check that done pulses are exactly one cycle wide.
- It SHALL check that busy is high for exactly WIDTH cycles per conversion.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin_to_bcd_seq : serial double-dabble binary-to-BCD, one bit per clock    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int                  c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_shift;
  logic [4*DIGITS-1:0]  r_work;
  logic [c_cnt_w-1:0]   r_cnt;

  logic [4*DIGITS-1:0]  w_adj;
  logic [4*DIGITS-1:0]  w_work_nxt;

  // Add-3 correction so each digit carries correctly into the next on shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign w_adj[4*i +: 4] = (r_work[4*i +: 4] >= 4'd5) ? r_work[4*i +: 4] + 4'd3
                                                         : r_work[4*i +: 4];
  end

  assign w_work_nxt = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_shift[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= bin;
            r_work  <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_work  <= w_work_nxt;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + c_one;
          // Only the completed result ever reaches the output register.
          if (r_cnt == c_last) begin
            bcd     <= w_work_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bin_to_bcd_seq : self-checking bench for bin_to_bcd_seq                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int n_pass;
  int n_total;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Decimal digits by plain divide/modulo.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0]  r;
    int unsigned  x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One conversion: checks latency, busy length, bcd stability, result, done width.
  task automatic do_conv(input logic [15:0] v, input logic [19:0] exp, input string tag);
    int          k;
    int          bc;
    bit          moved;
    logic [19:0] prev;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    prev  = bcd;
    @(negedge clk);
    start = 1'b0;
    bin   = ~v;
    k     = 1;
    bc    = 0;
    moved = 1'b0;
    while (!done && k < 100) begin
      if (busy) bc++;
      if (bcd !== prev) moved = 1'b1;
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'd17);
    check({tag, " busy_len"}, 32'(bc), 32'd16);
    check({tag, " bcd_stable"}, {31'd0, moved}, 32'd0);
    check({tag, " bcd"}, {12'd0, bcd}, {12'd0, exp});
    @(negedge clk);
    check({tag, " done_width"}, {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int          k;
    int          gap;
    bit          seen;
    logic [15:0] rv;

    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    bin     = 16'h0000;

    vecs[0]  = '{16'd0,     20'h00000};
    vecs[1]  = '{16'd65535, 20'h65535};
    vecs[2]  = '{16'd9999,  20'h09999};
    vecs[3]  = '{16'd1234,  20'h01234};
    vecs[4]  = '{16'd42,    20'h00042};
    vecs[5]  = '{16'd7,     20'h00007};
    vecs[6]  = '{16'd1,     20'h00001};
    vecs[7]  = '{16'd9,     20'h00009};
    vecs[8]  = '{16'd10,    20'h00010};
    vecs[9]  = '{16'd99999 - 16'd0 == 16'd0 ? 16'd0 : 16'd10000, 20'h10000};
    vecs[10] = '{16'd32768, 20'h32768};
    vecs[11] = '{16'd59999, 20'h59999};

    #2;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset bcd", {12'd0, bcd}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      do_conv(vecs[i].bin, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-to-back: start held, bin changed while busy.
    @(negedge clk);
    bin   = 16'd42;
    start = 1'b1;
    @(negedge clk);
    bin = 16'd7;
    k   = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b first latency", 32'(k), 32'd17);
    check("b2b first bcd", {12'd0, bcd}, 32'h00042);
    gap = 0;
    @(negedge clk);
    gap++;
    check("b2b reaccept busy", {31'd0, busy}, 32'd1);
    while (!done && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    start = 1'b0;
    check("b2b gap", 32'(gap), 32'd17);
    check("b2b second bcd", {12'd0, bcd}, 32'h00007);
    repeat (3) @(negedge clk);
    check("b2b no third", {31'd0, busy}, 32'd0);

    // Reset mid-conversion.
    @(negedge clk);
    bin   = 16'd500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("rst pre busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst bcd", {12'd0, bcd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("rst no done", {31'd0, seen}, 32'd0);
    check("rst bcd hold", {12'd0, bcd}, 32'd0);
    do_conv(16'd500, 20'h00500, "post_rst");

    // Randomized sweep against divide/modulo model.
    for (int i = 0; i < 1000; i++) begin
      rv = 16'($urandom_range(0, 65535));
      do_conv(rv, ref_bcd(32'(rv)), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
